// File: rtl/exec_pkg.sv
// Shared definitions for the execution unit.
//
// Contents:
//   DATA_W_DEF, ADDR_W_DEF  default operand and register-address widths
//   SHAMT_W                 shift-amount width taken from op_b
//   MUL_CNT_W               width of the multiplier iteration counter
//   opcode_e                operation encoding (8 = MUL, 9-15 illegal)
//   state_e                 control FSM states
package exec_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned SHAMT_W    = 5;
   localparam int unsigned MUL_CNT_W  = 6;

   typedef enum logic [3:0] {
      OpAdd = 4'd0,
      OpSub = 4'd1,
      OpAnd = 4'd2,
      OpOr  = 4'd3,
      OpXor = 4'd4,
      OpSlt = 4'd5,
      OpSll = 4'd6,
      OpSrl = 4'd7,
      OpMul = 4'd8
   } opcode_e;

   typedef enum logic [0:0] {
      StIdle,
      StMulBusy
   } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset, aborts any multiply in flight
//   start_i    load operands and begin (ignored while busy by the caller)
//   op_a_i     multiplicand
//   op_b_i     multiplier
//   done_o     high during the final iteration; product_o is valid with it
//   product_o  low DATA_W bits of op_a_i * op_b_i
//
// After start, DATA_W iterations run on the following DATA_W edges. done_o is
// combinational on the last iteration so the caller can register the result
// on the very edge that completes it.
module shift_add_mul
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   output logic              done_o,
   output logic [DATA_W-1:0] product_o
);

   localparam logic [MUL_CNT_W-1:0] LastIter = MUL_CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0]    mcand_q;
   logic [DATA_W-1:0]    mplier_q;
   logic [DATA_W-1:0]    acc_q;
   logic [DATA_W-1:0]    acc_d;
   logic [MUL_CNT_W-1:0] cnt_q;
   logic                 busy_q;

   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) begin
         acc_d = acc_q + mcand_q;
      end
   end

   assign done_o    = busy_q && (cnt_q == LastIter);
   assign product_o = acc_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= op_a_i;
         mplier_q <= op_b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         // Bits shifted past the top of mcand only affect product bits >= DATA_W.
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
         if (cnt_q == LastIter) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/exec_unit.sv
// Single-issue integer execution unit feeding a register-file write port.
//
// Ports:
//   clk, rst               clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready    operand bundle handshake
//   op_a, op_b             operands from register-file read ports
//   opcode                 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL,
//                          7 SRL, 8 MUL, 9-15 illegal
//   dest                   writeback register address
//   out_valid / out_ready  result handshake
//   out_data, out_addr     result and destination, held while stalled
//   out_we                 register-file write enable (valid and no error)
//   out_err                illegal or disabled opcode
//
// Build option: define EXEC_MUL_EN to include the iterative multiplier. When
// undefined, opcode 8 is reported as illegal and MUL_BUSY is never entered.
//
// Single-cycle ops produce a registered result on the accept edge. MUL
// occupies the unit for DATA_W cycles and blocks new bundles meanwhile.
module exec_unit
   import exec_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [3:0]        opcode,
   input  logic [ADDR_W-1:0] dest,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_we,
   output logic              out_err
);

   state_e            state_q;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic              out_err_q;

   logic              accept;
   logic              is_mul;
   logic              alu_err;
   logic [DATA_W-1:0] alu_res;
   logic              slt_lt;

   // Output slot is free when empty or being drained on this edge.
   assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   assign slt_lt = $signed(op_a) < $signed(op_b);

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      is_mul  = 1'b0;
      case (opcode)
         OpAdd:   alu_res = op_a + op_b;
         OpSub:   alu_res = op_a - op_b;
         OpAnd:   alu_res = op_a & op_b;
         OpOr:    alu_res = op_a | op_b;
         OpXor:   alu_res = op_a ^ op_b;
         OpSlt:   alu_res = {{(DATA_W-1){1'b0}}, slt_lt};
         OpSll:   alu_res = op_a << op_b[SHAMT_W-1:0];
         OpSrl:   alu_res = op_a >> op_b[SHAMT_W-1:0];
`ifdef EXEC_MUL_EN
         OpMul:   is_mul  = 1'b1;
`endif
         default: alu_err = 1'b1;
      endcase
   end

`ifdef EXEC_MUL_EN
   logic              mul_start;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [ADDR_W-1:0] mul_dest_q;

   assign mul_start = accept && is_mul;

   shift_add_mul #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (mul_start),
      .op_a_i    (op_a),
      .op_b_i    (op_b),
      .done_o    (mul_done),
      .product_o (mul_product)
   );
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_err_q   <= 1'b0;
`ifdef EXEC_MUL_EN
         mul_dest_q  <= '0;
`endif
      end else begin
         // Drain by default; a result loaded below on this edge takes priority.
         if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q <= StMulBusy;
`ifdef EXEC_MUL_EN
                     mul_dest_q <= dest;
`endif
                  end else begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= alu_res;
                     out_addr_q  <= dest;
                     out_err_q   <= alu_err;
                  end
               end
            end
            StMulBusy: begin
`ifdef EXEC_MUL_EN
               if (mul_done) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b1;
                  out_data_q  <= mul_product;
                  out_addr_q  <= mul_dest_q;
                  out_err_q   <= 1'b0;
               end
`else
               state_q <= StIdle;
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_err   = out_err_q;
   assign out_we    = out_valid_q && !out_err_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, away from the active edge.
module tb_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  opcode;
   logic [4:0]  dest;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_addr;
   logic        out_we;
   logic        out_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   exec_unit #(
      .DATA_W (32),
      .ADDR_W (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .opcode    (opcode),
      .dest      (dest),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_we    (out_we),
      .out_err   (out_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
      in_valid = 1'b1;
      opcode   = op;
      op_a     = a;
      op_b     = b;
      dest     = d;
   endtask

   initial begin
      logic [31:0] held_data;
      int          bad;

      rst       = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      opcode    = '0;
      dest      = '0;
      out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_we", out_we, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      rst = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 1);

      // ADD wraps to zero
      drive(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd3);
      tick();
      chk("add_valid", out_valid, 1);
      chk("add_data", out_data, 32'h0);
      chk("add_addr", out_addr, 3);
      chk("add_we", out_we, 1);
      chk("add_err", out_err, 0);

      // Back-to-back single-cycle ops
      drive(4'd1, 32'h5, 32'h7, 5'd1);
      tick();
      chk("sub_data", out_data, 32'hFFFF_FFFE);
      chk("sub_addr", out_addr, 1);
      drive(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd2);
      tick();
      chk("and_data", out_data, 32'h00F0_1200);
      drive(4'd3, 32'hA000_0001, 32'h0500_0010, 5'd30);
      tick();
      chk("or_data", out_data, 32'hA500_0011);
      chk("or_addr", out_addr, 30);
      drive(4'd5, 32'h8000_0000, 32'h1, 5'd4);
      tick();
      chk("slt_neg_lt_pos", out_data, 32'h1);
      drive(4'd5, 32'h1, 32'h8000_0000, 5'd4);
      tick();
      chk("slt_pos_lt_neg", out_data, 32'h0);
      drive(4'd7, 32'h8000_0000, 32'd31, 5'd5);
      tick();
      chk("srl_31", out_data, 32'h1);
      // Only op_b[4:0] is the shift amount
      drive(4'd6, 32'h1, 32'h24, 5'd6);
      tick();
      chk("sll_low_bits", out_data, 32'h10);
      chk("sll_valid", out_valid, 1);
      in_valid = 1'b0;
      tick();
      chk("idle_valid_low", out_valid, 0);

      // XOR result held under back-pressure; a pending ADD must not enter
      out_ready = 1'b0;
      drive(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7);
      tick();
      drive(4'd0, 32'h1, 32'h1, 5'd9);
      held_data = 32'h0FF0_0FF0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || out_data !== held_data || out_addr !== 5'd7 ||
             in_ready !== 1'b0 || out_we !== 1'b1) begin
            bad++;
         end
         tick();
      end
      chk("stall_stable_cycles", bad, 0);
      chk("stall_data", out_data, 32'h0FF0_0FF0);
      chk("stall_in_ready", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", in_ready, 1);
      chk("release_we", out_we, 1);
      tick();
      chk("release_single_write", out_valid, 0);
      tick();
      chk("release_stays_empty", out_valid, 0);

      // Illegal opcode 12
      drive(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8);
      tick();
      chk("ill12_valid", out_valid, 1);
      chk("ill12_err", out_err, 1);
      chk("ill12_data", out_data, 0);
      chk("ill12_we", out_we, 0);
      chk("ill12_addr", out_addr, 8);
      // Error clears on the next legal op
      drive(4'd0, 32'h2, 32'h3, 5'd10);
      tick();
      chk("after_ill_err", out_err, 0);
      chk("after_ill_data", out_data, 32'h5);
      chk("after_ill_we", out_we, 1);

`ifndef EXEC_MUL_EN
      drive(4'd8, 32'h0001_0000, 32'h0001_0001, 5'd11);
      tick();
      chk("mul_off_valid", out_valid, 1);
      chk("mul_off_err", out_err, 1);
      chk("mul_off_data", out_data, 0);
      chk("mul_off_we", out_we, 0);
      chk("mul_off_in_ready", in_ready, 1);
`endif

      // Asynchronous reset clears a held result mid-cycle
      drive(4'd0, 32'h2, 32'h3, 5'd5);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_addr", out_addr, 0);
      chk("async_rst_we", out_we, 0);
      rst       = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_valid", out_valid, 0);

`ifdef EXEC_MUL_EN
      // MUL: result exactly 32 edges after accept, inputs ignored while busy
      drive(4'd8, 32'h0001_0000, 32'h0001_0001, 5'd4);
      tick();
      chk("mul_busy_in_ready", in_ready, 0);
      drive(4'd0, 32'hDEAD_BEEF, 32'h1, 5'd9);
      bad = 0;
      for (int i = 1; i < 32; i++) begin
         tick();
         if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
         end
      end
      chk("mul_busy_cycles", bad, 0);
      in_valid = 1'b0;
      tick();
      chk("mul_valid", out_valid, 1);
      chk("mul_data", out_data, 32'h0001_0000);
      chk("mul_addr", out_addr, 4);
      chk("mul_we", out_we, 1);
      tick();
      chk("mul_drained", out_valid, 0);

      // Reset during a MUL aborts it
      drive(4'd8, 32'h3, 32'h5, 5'd6);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      rst = 1'b0;
      #1;
      chk("mul_abort_valid", out_valid, 0);
      chk("mul_abort_data", out_data, 0);
      chk("mul_abort_in_ready", in_ready, 1);
      #2;
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid !== 1'b0) begin
            bad++;
         end
      end
      chk("mul_abort_no_result", bad, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
